// File: rtl/axi4lite_reg_slave.sv
// axi4lite_reg_slave: AXI4-Lite subordinate exposing 2**ADDR_WIDTH registers
// of DATA_WIDTH bits each, with all register contents exported on regs_o.
// AW and W are accepted independently. A write commits once both address and
// data are available. One write and one read may be outstanding at a time.
// Optional feature macro AXIL_SLV_RO_ID_EN: when defined, the highest index
// becomes a read-only ID register that returns ID_VALUE. Writes to it are
// dropped and answered with SLVERR.
module axi4lite_reg_slave #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE = 8'hA5
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [ADDR_WIDTH-1:0]                  s_awaddr,
  input  logic                                   s_awvalid,
  output logic                                   s_awready,
  input  logic [DATA_WIDTH-1:0]                  s_wdata,
  input  logic                                   s_wvalid,
  output logic                                   s_wready,
  output logic [1:0]                             s_bresp,
  output logic                                   s_bvalid,
  input  logic                                   s_bready,
  input  logic [ADDR_WIDTH-1:0]                  s_araddr,
  input  logic                                   s_arvalid,
  output logic                                   s_arready,
  output logic [DATA_WIDTH-1:0]                  s_rdata,
  output logic [1:0]                             s_rresp,
  output logic                                   s_rvalid,
  input  logic                                   s_rready,
  output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]  regs_o
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] RO_IDX = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXIL_SLV_RO_ID_EN
  localparam bit RO_EN = 1'b1;
`else
  localparam bit RO_EN = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] held_addr;
  logic [DATA_WIDTH-1:0] held_data;

  logic                  aw_fire;
  logic                  w_fire;
  logic                  commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ro;
  logic                  ar_fire;
  logic [DATA_WIDTH-1:0] rd_value;

  // Readies depend only on internal state, forced low while reset is asserted.
  assign s_awready = !rst && !aw_held && !s_bvalid;
  assign s_wready  = !rst && !w_held  && !s_bvalid;
  assign s_arready = !rst && !s_rvalid;

  // Decode handshakes and pick write address/data from the holding regs or the bus.
  always_comb begin
    aw_fire = s_awvalid && s_awready;
    w_fire  = s_wvalid && s_wready;
    commit  = (aw_held || aw_fire) && (w_held || w_fire);
    wr_addr = aw_held ? held_addr : s_awaddr;
    wr_data = w_held ? held_data : s_wdata;
    wr_ro   = RO_EN && (wr_addr == RO_IDX);
  end

  // Write path: hold a lone AW or W, commit when both are present, then drain B.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      held_addr <= '0;
      held_data <= '0;
      s_bvalid  <= 1'b0;
      s_bresp   <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit) begin
      if (!wr_ro) begin
        regs[wr_addr] <= wr_data;
      end
      s_bvalid <= 1'b1;
      s_bresp  <= wr_ro ? RESP_SLVERR : RESP_OKAY;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
    end else begin
      if (aw_fire) begin
        aw_held   <= 1'b1;
        held_addr <= s_awaddr;
      end
      if (w_fire) begin
        w_held    <= 1'b1;
        held_data <= s_wdata;
      end
      if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0;
      end
    end
  end

  // Read value seen on the AR bus; a colliding write lands after this sample.
  always_comb begin
    ar_fire  = s_arvalid && s_arready;
    rd_value = (RO_EN && (s_araddr == RO_IDX)) ? ID_VALUE : regs[s_araddr];
  end

  // Read path: capture data on AR, hold R stable until the master takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= RESP_OKAY;
    end else if (ar_fire) begin
      s_rvalid <= 1'b1;
      s_rdata  <= rd_value;
      s_rresp  <= RESP_OKAY;
    end else if (s_rvalid && s_rready) begin
      s_rvalid <= 1'b0;
    end
  end

  // Flatten the bank for parallel use; the ID slot shows its constant.
  always_comb begin
    regs_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_o[i*DATA_WIDTH +: DATA_WIDTH] = (RO_EN && (i == NUM_REGS - 1)) ? ID_VALUE : regs[i];
    end
  end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// tb_axi4lite_reg_slave: directed self-checking bench for axi4lite_reg_slave.
// Expected values are hand-computed constants. The RO ID block is selected with
// AXIL_SLV_RO_ID_EN, the same macro that enables that feature in the design.
module tb_axi4lite_reg_slave;

  logic       clk;
  logic       rst;
  logic [1:0] s_awaddr;
  logic       s_awvalid;
  logic       s_awready;
  logic [7:0] s_wdata;
  logic       s_wvalid;
  logic       s_wready;
  logic [1:0] s_bresp;
  logic       s_bvalid;
  logic       s_bready;
  logic [1:0] s_araddr;
  logic       s_arvalid;
  logic       s_arready;
  logic [7:0] s_rdata;
  logic [1:0] s_rresp;
  logic       s_rvalid;
  logic       s_rready;
  logic [31:0] regs_o;

  int errors = 0;
  int checks = 0;

`ifdef AXIL_SLV_RO_ID_EN
  localparam logic [31:0] RESET_REGS = 32'hA500_0000;
`else
  localparam logic [31:0] RESET_REGS = 32'h0000_0000;
`endif

  axi4lite_reg_slave #(
    .ADDR_WIDTH(2),
    .DATA_WIDTH(8),
    .ID_VALUE(8'hA5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_awaddr(s_awaddr),
    .s_awvalid(s_awvalid),
    .s_awready(s_awready),
    .s_wdata(s_wdata),
    .s_wvalid(s_wvalid),
    .s_wready(s_wready),
    .s_bresp(s_bresp),
    .s_bvalid(s_bvalid),
    .s_bready(s_bready),
    .s_araddr(s_araddr),
    .s_arvalid(s_arvalid),
    .s_arready(s_arready),
    .s_rdata(s_rdata),
    .s_rresp(s_rresp),
    .s_rvalid(s_rvalid),
    .s_rready(s_rready),
    .regs_o(regs_o)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Same-cycle AW+W issue; checks the B response appears one cycle later
  task automatic applyStimulus(input string tag, input logic [1:0] addr, input logic [7:0] data,
                               input logic [1:0] exp_resp);
    s_awaddr  = addr;
    s_awvalid = 1'b1;
    s_wdata   = data;
    s_wvalid  = 1'b1;
    tick();
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    checkOutput({tag, "_bvalid"}, {31'd0, s_bvalid}, 32'd1);
    checkOutput({tag, "_bresp"}, {30'd0, s_bresp}, {30'd0, exp_resp});
  endtask

  // Single read with rready high; checks R one cycle later and its drain
  task automatic readReg(input string tag, input logic [1:0] addr, input logic [7:0] exp_data);
    s_rready  = 1'b1;
    s_araddr  = addr;
    s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    checkOutput({tag, "_rvalid"}, {31'd0, s_rvalid}, 32'd1);
    checkOutput({tag, "_rdata"}, {24'd0, s_rdata}, {24'd0, exp_data});
    checkOutput({tag, "_rresp"}, {30'd0, s_rresp}, 32'd0);
    tick();
    checkOutput({tag, "_rvalid_drop"}, {31'd0, s_rvalid}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    s_awaddr  = '0;
    s_awvalid = 1'b0;
    s_wdata   = '0;
    s_wvalid  = 1'b0;
    s_bready  = 1'b1;
    s_araddr  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b1;

    // Reset held for 3 cycles
    repeat (3) tick();
    checkOutput("rst_awready", {31'd0, s_awready}, 32'd0);
    checkOutput("rst_wready", {31'd0, s_wready}, 32'd0);
    checkOutput("rst_arready", {31'd0, s_arready}, 32'd0);
    checkOutput("rst_regs", regs_o, RESET_REGS);
    checkOutput("rst_bvalid", {31'd0, s_bvalid}, 32'd0);
    checkOutput("rst_rvalid", {31'd0, s_rvalid}, 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("post_rst_readies", {29'd0, s_awready, s_wready, s_arready}, 32'd7);

    // Same-cycle AW/W to addr 2, then read back
    applyStimulus("wr2", 2'd2, 8'h04, 2'b00);
    checkOutput("wr2_regs", {24'd0, regs_o[23:16]}, 32'h04);
    checkOutput("wr2_awready_busy", {31'd0, s_awready}, 32'd0);
    tick();
    checkOutput("wr2_bvalid_drop", {31'd0, s_bvalid}, 32'd0);
    readReg("rd2", 2'd2, 8'h04);

    // Split write: W first, AW three edges later
    s_wdata  = 8'h3C;
    s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    checkOutput("split_wready_low", {31'd0, s_wready}, 32'd0);
    checkOutput("split_awready_high", {31'd0, s_awready}, 32'd1);
    checkOutput("split_no_b0", {31'd0, s_bvalid}, 32'd0);
    tick();
    checkOutput("split_no_b1", {31'd0, s_bvalid}, 32'd0);
    tick();
    checkOutput("split_no_b2", {31'd0, s_bvalid}, 32'd0);
    checkOutput("split_reg_unwritten", {24'd0, regs_o[15:8]}, 32'h00);
    s_awaddr  = 2'd1;
    s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    checkOutput("split_bvalid", {31'd0, s_bvalid}, 32'd1);
    checkOutput("split_reg", {24'd0, regs_o[15:8]}, 32'h3C);
    tick();
    readReg("rd1", 2'd1, 8'h3C);

    // Backpressure on B with a new AW waiting
    s_bready = 1'b0;
    applyStimulus("bp", 2'd1, 8'h9A, 2'b00);
    s_awaddr  = 2'd0;
    s_awvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("bp_bvalid", {31'd0, s_bvalid}, 32'd1);
      checkOutput("bp_bresp", {30'd0, s_bresp}, 32'd0);
      checkOutput("bp_readies", {30'd0, s_awready, s_wready}, 32'd0);
    end
    s_bready = 1'b1;
    tick();
    checkOutput("bp_release", {31'd0, s_bvalid}, 32'd0);
    checkOutput("bp_awready_back", {31'd0, s_awready}, 32'd1);
    tick();
    s_awvalid = 1'b0;
    checkOutput("bp_aw_taken", {31'd0, s_awready}, 32'd0);
    checkOutput("bp_no_b", {31'd0, s_bvalid}, 32'd0);
    s_wdata  = 8'h11;
    s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    checkOutput("bp2_bvalid", {31'd0, s_bvalid}, 32'd1);
    checkOutput("bp2_regs", {16'd0, regs_o[15:0]}, 32'h9A11);
    tick();

    // Write commit and read of addr 0 on the same edge
    s_awaddr  = 2'd0;
    s_awvalid = 1'b1;
    s_wdata   = 8'h55;
    s_wvalid  = 1'b1;
    s_araddr  = 2'd0;
    s_arvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    s_arvalid = 1'b0;
    checkOutput("col_rvalid", {31'd0, s_rvalid}, 32'd1);
    checkOutput("col_rdata_old", {24'd0, s_rdata}, 32'h11);
    checkOutput("col_bvalid", {31'd0, s_bvalid}, 32'd1);
    checkOutput("col_regs", {24'd0, regs_o[7:0]}, 32'h55);
    tick();
    readReg("col_rd", 2'd0, 8'h55);

    // R backpressure: data held while rready low
    s_rready  = 1'b0;
    s_araddr  = 2'd2;
    s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    s_araddr  = 2'd0;
    repeat (2) tick();
    checkOutput("rbp_rvalid", {31'd0, s_rvalid}, 32'd1);
    checkOutput("rbp_rdata", {24'd0, s_rdata}, 32'h04);
    checkOutput("rbp_arready", {31'd0, s_arready}, 32'd0);
    s_rready = 1'b1;
    tick();
    checkOutput("rbp_drain", {31'd0, s_rvalid}, 32'd0);

    // Top index: read-only ID or plain register depending on build
`ifdef AXIL_SLV_RO_ID_EN
    applyStimulus("ro_wr", 2'd3, 8'hFF, 2'b10);
    checkOutput("ro_regs", {24'd0, regs_o[31:24]}, 32'hA5);
    tick();
    readReg("ro_rd", 2'd3, 8'hA5);
`else
    applyStimulus("top_wr", 2'd3, 8'hFF, 2'b00);
    checkOutput("top_regs", {24'd0, regs_o[31:24]}, 32'hFF);
    tick();
    readReg("top_rd", 2'd3, 8'hFF);
`endif

    // Reset with an AW held: the held address must be dropped
    s_awaddr  = 2'd1;
    s_awvalid = 1'b1;
    tick();
    s_awvalid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_regs", regs_o, RESET_REGS);
    s_wdata  = 8'h77;
    s_wvalid = 1'b1;
    tick();
    s_wvalid = 1'b0;
    tick();
    checkOutput("mid_rst_no_b", {31'd0, s_bvalid}, 32'd0);
    checkOutput("mid_rst_regs2", regs_o, RESET_REGS);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi4lite_reg_slave.md
# axi4lite_reg_slave

AXI4-Lite responder exposing a bank of 2**ADDR_WIDTH registers, each DATA_WIDTH bits wide. It is the subordinate end of the AXI4-Lite link driven by the master inside `tt_um_axi4lite_top`. It accepts AW and W independently, issues one B response per write and one R response per read, and honours backpressure on both response channels. The register contents are also exported in parallel for use by other logic in the design.

## Interface
Parameters:
- ADDR_WIDTH, 2, register index width (word addressing, no byte offset).
- DATA_WIDTH, 8, register and data-bus width.
- ID_VALUE, 8'hA5, constant returned by the read-only ID register (used only with the macro enabled; truncated or zero-extended to DATA_WIDTH).

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- s_awaddr  input  ADDR_WIDTH  write address.
- s_awvalid  input  1  write address valid.
- s_awready  output  1  write address ready.
- s_wdata  input  DATA_WIDTH  write data.
- s_wvalid  input  1  write data valid.
- s_wready  output  1  write data ready.
- s_bresp  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- s_bvalid  output  1  write response valid.
- s_bready  input  1  write response ready.
- s_araddr  input  ADDR_WIDTH  read address.
- s_arvalid  input  1  read address valid.
- s_arready  output  1  read address ready.
- s_rdata  output  DATA_WIDTH  read data.
- s_rresp  output  2  read response.
- s_rvalid  output  1  read response valid.
- s_rready  input  1  read response ready.
- regs_o  output  (2**ADDR_WIDTH)*DATA_WIDTH  all registers flattened; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

## Operation
- Reset (asynchronous): all registers are cleared to 0.
  - bvalid, rvalid, bresp, rresp and rdata are 0; address and data holding flags are cleared.
  - All ready outputs are 0 while rst is high.
- Write state: aw_held and w_held flags, plus a held address and held data.
  - s_awready = !aw_held && !s_bvalid.
  - s_wready = !w_held && !s_bvalid.
  - An AW handshake with no W available latches the address. A W handshake with no AW available latches the data.
- Write commit: occurs at the edge where both address and data are available, each either held or handshaking in that cycle.
  - At that edge the register is written, bvalid is set, and both held flags are cleared.
  - bvalid holds, with bresp stable, until the edge where s_bready is high. AW and W acceptance resumes in the following cycle.
- Read: s_arready = !s_rvalid.
  - On an AR handshake, rdata is loaded with the register value, rresp is set to OKAY and rvalid is set.
  - rvalid, rdata and rresp remain stable until the rready handshake.
- Simultaneous write commit and read of the same index at the same edge: the read returns the pre-write value.
- Read and write channels are fully independent. At most one write and one read are outstanding.
- Reset mid-transaction: held and pending transactions are dropped; no response is issued.

## Timing
- Write with AW and W in the same cycle (edge N): register and regs_o updated after N; s_bvalid high in cycle N+1.
- Write with AW at edge N and W at edge M > N: commit and bvalid after M. s_awready is low from N+1 until the B handshake completes.
- Read with AR at edge N: s_rvalid and s_rdata valid in cycle N+1.
- Back-to-back throughput with bready/rready tied high: one write every 2 cycles, one read every 2 cycles.
- All outputs except the ready signals are registered. The ready signals are combinational from internal state only, never from inputs.

## Configuration
- AXIL_SLV_RO_ID_EN defined: the highest index (2**ADDR_WIDTH-1) is read-only.
  - Reads of it return ID_VALUE with OKAY.
  - Writes to it leave it unchanged and return bresp=SLVERR.
  - Its regs_o slice shows ID_VALUE.
- AXIL_SLV_RO_ID_EN undefined: all registers are read/write and every response is OKAY.

## Test plan
- Reset: hold rst high for 3 cycles, then release. Required: all readies 0 during reset, regs_o=0, bvalid=rvalid=0. Readies go to 1 in the first cycle after release.
- Same-cycle AW/W: addr 2, data 8'h04, bready=1. Required: bvalid=1 one cycle later with bresp=00 and regs_o[23:16]=8'h04. Then AR addr 2 gives rvalid next cycle with rdata=8'h04 and rresp=00.
- Split write: W data 8'h3C first, AW addr 1 three cycles later. Required: wready low after the W handshake, bvalid only after the AW edge, register 1 = 8'h3C.
- Backpressure: bready=0 for 4 cycles after a write. Required: bvalid and bresp stable throughout, awready and wready stay 0, and a new AW is accepted only after bready=1.
- Collision: a write of 8'h55 to addr 0 (previous value 8'h11) commits on the same edge as AR addr 0. Required: rdata=8'h11; a subsequent read returns 8'h55.
- With AXIL_SLV_RO_ID_EN: write 8'hFF to addr 3. Required: bresp=10, and a read of addr 3 returns 8'hA5 with rresp=00.
